// File: rtl/jtkcpu_fetch_pkg.sv
// Shared encodings for the KCPU fetch unit and its sequencer.
package jtkcpu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_BYTE = 2'd2
  } fetch_state_e;

  localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/jtkcpu_fetch.sv
// KCPU instruction fetch: owns pc, reads opcode/operand bytes from the byte bus.
// Request to data valid is 2 cen cycles (opcode, 8-bit operand) or 3 (16-bit); bus_wait holds all state.
module jtkcpu_fetch
  import jtkcpu_fetch_pkg::*;
#(
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        ni,
  input  logic        opd,
  input  logic        memhi,
  input  logic        pc_jmp,
  input  logic [15:0] jmp_addr,
  input  logic [7:0]  din,
  input  logic        bus_wait,
  output logic [15:0] addr,
  output logic        rd,
  output logic [7:0]  op,
  output logic [15:0] mdata,
  output logic [15:0] pc,
  output logic        mem_busy,
  output logic        op_ok,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic         cnt_q, cnt_d;
  logic [15:0]  addr_q, addr_d;
  logic         rd_q, rd_d;
  logic [7:0]   op_q, op_d;
  logic [15:0]  mdata_q, mdata_d;
  logic [15:0]  pc_q, pc_d;
  logic         op_ok_q, op_ok_d;
  logic         err_q, err_d;

  logic [15:0]  pc_base;
  logic [15:0]  pc_inc;

  // A jump in the same cycle as a request redirects that request's address.
  assign pc_base = pc_jmp ? jmp_addr : pc_q;
  assign pc_inc  = pc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    op_d    = op_q;
    mdata_d = mdata_q;
    pc_d    = pc_q;
    op_ok_d = op_ok_q;
    err_d   = err_q;
    if (cen) begin
      op_ok_d = 1'b0;
      if ((ni && opd) || ((state_q != ST_IDLE) && (ni || opd || pc_jmp))) err_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pc_jmp) pc_d = jmp_addr;
          if (ni) begin
            addr_d  = pc_base;
            rd_d    = 1'b1;
            state_d = ST_OPC;
          end else if (opd) begin
            addr_d  = pc_base;
            rd_d    = 1'b1;
            cnt_d   = memhi;
            state_d = ST_BYTE;
          end
        end
        ST_OPC: begin
          if (!bus_wait) begin
            op_d    = din;
            pc_d    = pc_inc;
            rd_d    = 1'b0;
            op_ok_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BYTE: begin
          if (!bus_wait) begin
            mdata_d = {mdata_q[7:0], din};
            pc_d    = pc_inc;
            if (cnt_q) begin
              cnt_d  = 1'b0;
              addr_d = pc_inc;
            end else begin
              rd_d    = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 1'b0;
      addr_q  <= 16'h0000;
      rd_q    <= 1'b0;
      op_q    <= OP_NOP;
      mdata_q <= 16'h0000;
      pc_q    <= PC_RST;
      op_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      mdata_q <= mdata_d;
      pc_q    <= pc_d;
      op_ok_q <= op_ok_d;
      err_q   <= err_d;
    end
  end

  assign addr     = addr_q;
  assign rd       = rd_q;
  assign op       = op_q;
  assign mdata    = mdata_q;
  assign pc       = pc_q;
  assign op_ok    = op_ok_q;
  assign err      = err_q;
  assign mem_busy = rst_n & ((state_q != ST_IDLE) | ni | opd);

endmodule

// File: tb/tb_jtkcpu_fetch.sv
// Self-checking bench for jtkcpu_fetch: byte-memory bus model plus a transaction-level reference.
module tb_jtkcpu_fetch;

  localparam logic [15:0] PC_RST = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, cen, ni, opd, memhi, pc_jmp, bus_wait;
  logic [15:0] jmp_addr;
  logic [7:0]  din;
  logic [15:0] addr, mdata, pc;
  logic        rd, mem_busy, op_ok, err;
  logic [7:0]  op;

  logic [7:0]  mem [65536];

  int checks   = 0;
  int failures = 0;

  // Reference state: what the sequencer should see after each transaction.
  logic [15:0] m_pc;
  logic [7:0]  m_op;
  logic [15:0] m_mdata;
  logic        m_err;

  always #5 clk = ~clk;

  assign din = mem[addr];

  jtkcpu_fetch #(.PC_RST(PC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .ni(ni), .opd(opd), .memhi(memhi),
    .pc_jmp(pc_jmp), .jmp_addr(jmp_addr), .din(din), .bus_wait(bus_wait),
    .addr(addr), .rd(rd), .op(op), .mdata(mdata), .pc(pc),
    .mem_busy(mem_busy), .op_ok(op_ok), .err(err)
  );

  task automatic model_reset();
    m_pc    = PC_RST;
    m_op    = 8'h00;
    m_mdata = 16'h0000;
    m_err   = 1'b0;
  endtask

  // One fetch transaction from IDLE; entered and left at posedge+1.
  task automatic run_xact(input bit k_ni, input bit k_opd, input bit k_hi, input bit k_jmp,
                          input logic [15:0] tgt, input int max_waits, input bit exact_waits,
                          input bit rand_cen, input bit inject, input string name);
    logic [15:0] start;
    logic [15:0] exp_addr [2];
    logic [15:0] aq [$];
    int nbytes, busy, rdc, waits, okc, cyc, waits_used;
    bit cen_prev;
    start  = k_jmp ? tgt : m_pc;
    nbytes = (!k_ni && k_hi) ? 2 : 1;
    for (int i = 0; i < 2; i++) exp_addr[i] = start + 16'(i);
    if (k_ni) m_op = mem[start];
    else for (int i = 0; i < nbytes; i++) m_mdata = {m_mdata[7:0], mem[exp_addr[i]]};
    m_pc = start + 16'(nbytes);
    if ((k_ni && k_opd) || inject) m_err = 1'b1;

    cen = 1'b1; ni = k_ni; opd = k_opd; memhi = k_hi; pc_jmp = k_jmp; jmp_addr = tgt; bus_wait = 1'b0;
    busy = 0; rdc = 0; waits = 0; okc = 0; cyc = 0; waits_used = 0;
    while (cyc < 80) begin
      #1;
      if (cyc == 0) begin
        checks++;
        if (mem_busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_on_request: mem_busy=%b want 1", name, mem_busy);
        end
      end
      if (cyc > 0 && !mem_busy) break;
      if (cen) begin
        if (mem_busy) busy++;
        if (rd) rdc++;
        if (rd && bus_wait) waits++;
        if (rd && !bus_wait) aq.push_back(addr);
      end
      cen_prev = cen;
      @(posedge clk); #1;
      cyc++;
      if (cen_prev && op_ok) okc++;
      ni = 1'b0; opd = 1'b0; memhi = 1'b0; pc_jmp = 1'b0;
      cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (inject && cyc == 1) begin
        ni  = 1'b1;
        cen = 1'b1;
      end
      bus_wait = 1'b0;
      if (waits_used < max_waits) begin
        bus_wait = exact_waits ? 1'b1 : 1'($urandom_range(0, 1));
        if (bus_wait && cen) waits_used++;
      end
    end
    cen = 1'b1; bus_wait = 1'b0;

    checks++;
    if (cyc >= 80) begin
      failures++;
      $display("FAIL %s timeout: mem_busy still %b after %0d cycles", name, mem_busy, cyc);
    end
    checks++;
    if (busy != 1 + nbytes + waits) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy, 1 + nbytes + waits);
    end
    checks++;
    if (rdc != nbytes + waits) begin
      failures++;
      $display("FAIL %s rd_cycles: got %0d want %0d", name, rdc, nbytes + waits);
    end
    if (exact_waits) begin
      checks++;
      if (waits != max_waits) begin
        failures++;
        $display("FAIL %s wait_cycles: got %0d want %0d", name, waits, max_waits);
      end
    end
    checks++;
    if (aq.size() != nbytes) begin
      failures++;
      $display("FAIL %s bus_reads: got %0d want %0d", name, aq.size(), nbytes);
    end else begin
      for (int i = 0; i < nbytes; i++) begin
        checks++;
        if (aq[i] !== exp_addr[i]) begin
          failures++;
          $display("FAIL %s addr[%0d]: got %h want %h", name, i, aq[i], exp_addr[i]);
        end
      end
    end
    checks++;
    if (okc != (k_ni ? 1 : 0)) begin
      failures++;
      $display("FAIL %s op_ok_pulses: got %0d want %0d", name, okc, k_ni ? 1 : 0);
    end
    checks++;
    if (op !== m_op) begin
      failures++;
      $display("FAIL %s op: got %h want %h", name, op, m_op);
    end
    checks++;
    if (mdata !== m_mdata) begin
      failures++;
      $display("FAIL %s mdata: got %h want %h", name, mdata, m_mdata);
    end
    checks++;
    if (pc !== m_pc) begin
      failures++;
      $display("FAIL %s pc: got %h want %h", name, pc, m_pc);
    end
    checks++;
    if (err !== m_err) begin
      failures++;
      $display("FAIL %s err: got %b want %b", name, err, m_err);
    end
  endtask

  task automatic do_jump(input logic [15:0] tgt);
    cen = 1'b1; pc_jmp = 1'b1; jmp_addr = tgt;
    #1;
    checks++;
    if (mem_busy !== 1'b0) begin
      failures++;
      $display("FAIL jump_busy: mem_busy=%b want 0", mem_busy);
    end
    @(posedge clk); #1;
    pc_jmp = 1'b0;
    m_pc = tgt;
    checks++;
    if (pc !== m_pc) begin
      failures++;
      $display("FAIL jump_pc: got %h want %h", pc, m_pc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ni = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({addr, rd, op, mdata, pc, op_ok, err, mem_busy} !== {16'h0000, 1'b0, 8'h00, 16'h0000, PC_RST, 3'b000}) begin
      failures++;
      $display("FAIL reset_values: addr=%h rd=%b op=%h mdata=%h pc=%h op_ok=%b err=%b busy=%b", addr, rd, op, mdata, pc, op_ok, err, mem_busy);
    end
    ni = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_busy !== 1'b0 || pc !== PC_RST) begin
      failures++;
      $display("FAIL reset_release: busy=%b pc=%h want 0 %h", mem_busy, pc, PC_RST);
    end
  endtask

  task automatic test_jump_ni();
    do_jump(16'h8000);
    run_xact(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, "jump_ni");
    @(posedge clk); #1;
    checks++;
    if (op_ok !== 1'b0) begin
      failures++;
      $display("FAIL op_ok_clear: got %b want 0", op_ok);
    end
  endtask

  task automatic test_operand16();
    run_xact(0, 1, 1, 0, 16'h0, 0, 0, 0, 0, "operand16");
  endtask

  task automatic test_bus_wait();
    run_xact(0, 1, 0, 0, 16'h0, 4, 1, 0, 0, "bus_wait");
  endtask

  task automatic test_wrap();
    do_jump(16'hFFFF);
    run_xact(0, 1, 1, 0, 16'h0, 0, 0, 0, 0, "wrap");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind;
      bit jmp;
      logic [15:0] tgt;
      kind = $urandom_range(0, 2);
      jmp  = ($urandom_range(0, 3) == 0);
      tgt  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      run_xact(kind == 0, kind != 0, kind == 2, jmp, tgt, $urandom_range(0, 3), 0, 1, 0, "random");
    end
  endtask

  task automatic test_protocol();
    run_xact(0, 1, 1, 0, 16'h0, 0, 0, 0, 1, "ni_in_byte");
    run_xact(1, 1, 0, 0, 16'h0, 1, 0, 0, 0, "ni_and_opd");
    run_xact(0, 1, 0, 0, 16'h0, 0, 0, 0, 0, "err_sticky");
  endtask

  task automatic test_reset_mid();
    do_jump(16'h4000);
    cen = 1'b1; opd = 1'b1; memhi = 1'b1;
    @(posedge clk); #1;
    opd = 1'b0; memhi = 1'b0;
    @(posedge clk); #1;
    ni = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({addr, rd, op, mdata, pc, op_ok, err, mem_busy} !== {16'h0000, 1'b0, 8'h00, 16'h0000, PC_RST, 3'b000}) begin
      failures++;
      $display("FAIL reset_mid: addr=%h rd=%b op=%h mdata=%h pc=%h op_ok=%b err=%b busy=%b", addr, rd, op, mdata, pc, op_ok, err, mem_busy);
    end
    ni = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_xact(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h8000] = 8'h86;
    mem[16'h8001] = 8'h12;
    mem[16'h8002] = 8'h34;
    mem[16'h8003] = 8'h5A;
    mem[16'hFFFF] = 8'hAB;
    mem[16'h0000] = 8'hCD;
    rst_n = 1'b0; cen = 1'b0; ni = 1'b0; opd = 1'b0; memhi = 1'b0;
    pc_jmp = 1'b0; jmp_addr = 16'h0000; bus_wait = 1'b0;

    test_reset();
    test_jump_ni();
    test_operand16();
    test_bus_wait();
    test_wrap();
    test_random();
    test_protocol();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
